// File: rtl/regwrite_arbiter.sv
// ---------------------------------------------------------------------------
// regwrite_arbiter
//   Shares the single register-file write port between NUM_FU functional
//   units. One requester is granted per cycle (round-robin by default). The
//   granted write is registered onto the rf_* port one cycle later. Every
//   requesting FU that loses is stalled through fu_stall.
//
//   Build option: define REGWRITE_ARB_FIXED_PRIO_EN for fixed priority, where
//   the lowest index wins and no rotating pointer is kept. Timing is
//   otherwise identical.
//
// Ports
//   clk       : clock, all state updates on posedge
//   rst       : asynchronous active-high reset
//   req_we    : per-FU write request
//   req_addr  : per-FU write address, FU i at [i*ADDR_W +: ADDR_W]
//   req_data  : per-FU write data,    FU i at [i*DATA_W +: DATA_W]
//   grant     : one-hot grant, combinational, same cycle as request
//   fu_stall  : req_we & ~grant, combinational
//   rf_we     : register-file write enable (registered)
//   rf_waddr  : register-file write address (registered)
//   rf_wdata  : register-file write data (registered)
//   busy      : registered, 1 if any request was present last cycle
// ---------------------------------------------------------------------------
module regwrite_arbiter #(
  parameter int NUM_FU = 4,
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_FU-1:0]          req_we,
  input  logic [NUM_FU*ADDR_W-1:0]   req_addr,
  input  logic [NUM_FU*DATA_W-1:0]   req_data,
  output logic [NUM_FU-1:0]          grant,
  output logic [NUM_FU-1:0]          fu_stall,
  output logic                       rf_we,
  output logic [ADDR_W-1:0]          rf_waddr,
  output logic [DATA_W-1:0]          rf_wdata,
  output logic                       busy
);

  logic [NUM_FU-1:0] grant_next;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic [ADDR_W-1:0] addr_masked [NUM_FU];
  logic [DATA_W-1:0] data_masked [NUM_FU];

`ifdef REGWRITE_ARB_FIXED_PRIO_EN
  // Fixed priority: first set bit from index 0 upward.
  always_comb begin
    logic found;
    grant_next = '0;
    found      = 1'b0;
    for (int k = 0; k < NUM_FU; k++) begin
      if (!found && req_we[k]) begin
        found         = 1'b1;
        grant_next[k] = 1'b1;
      end
    end
  end
`else
  localparam int PTR_W = $clog2(NUM_FU);

  logic [PTR_W-1:0] rr_ptr_reg;
  logic [PTR_W-1:0] grant_idx;

  // Round-robin: scan NUM_FU positions starting at rr_ptr_reg, wrapping
  // past NUM_FU-1 back to 0; the first requester found wins.
  always_comb begin
    int   idx;
    logic found;
    grant_next = '0;
    grant_idx  = '0;
    found      = 1'b0;
    idx        = 0;
    for (int k = 0; k < NUM_FU; k++) begin
      idx = int'(rr_ptr_reg) + k;
      if (idx >= NUM_FU) idx = idx - NUM_FU;
      if (!found && req_we[idx]) begin
        found           = 1'b1;
        grant_next[idx] = 1'b1;
        grant_idx       = PTR_W'(idx);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_reg <= '0;
    end else if (|grant) begin
      rr_ptr_reg <= (grant_idx == PTR_W'(NUM_FU - 1)) ? '0
                                                      : grant_idx + PTR_W'(1);
    end
  end
`endif

  // Outputs are forced quiet while reset is held so no FU sees a grant or
  // stall from an arbiter that is being cleared.
  assign grant    = rst ? '0 : grant_next;
  assign fu_stall = rst ? '0 : (req_we & ~grant_next);

  // One-hot grant lets the write-port mux be a plain AND-OR tree.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_FU; gi++) begin : g_mask
      assign addr_masked[gi] = {ADDR_W{grant_next[gi]}} & req_addr[gi*ADDR_W +: ADDR_W];
      assign data_masked[gi] = {DATA_W{grant_next[gi]}} & req_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      sel_addr = sel_addr | addr_masked[k];
      sel_data = sel_data | data_masked[k];
    end
  end

  // Write port: address/data hold their old values when nothing is granted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      busy     <= 1'b0;
    end else begin
      rf_we <= |grant;
      busy  <= |req_we;
      if (|grant) begin
        rf_waddr <= sel_addr;
        rf_wdata <= sel_data;
      end
    end
  end

endmodule

// File: tb/tb_regwrite_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regwrite_arbiter
//   Directed bench for regwrite_arbiter (NUM_FU=4, DATA_W=64, ADDR_W=5).
//   Each comparison is an immediate assertion; one line per check.
//   Honors REGWRITE_ARB_FIXED_PRIO_EN for the grant-order expectations.
// ---------------------------------------------------------------------------
module tb_regwrite_arbiter;

  localparam int NUM_FU = 4;
  localparam int DATA_W = 64;
  localparam int ADDR_W = 5;

  logic                     clk;
  logic                     rst;
  logic [NUM_FU-1:0]        req_we;
  logic [NUM_FU*ADDR_W-1:0] req_addr;
  logic [NUM_FU*DATA_W-1:0] req_data;
  logic [NUM_FU-1:0]        grant;
  logic [NUM_FU-1:0]        fu_stall;
  logic                     rf_we;
  logic [ADDR_W-1:0]        rf_waddr;
  logic [DATA_W-1:0]        rf_wdata;
  logic                     busy;

  int n_total;
  int n_pass;

  regwrite_arbiter #(
    .NUM_FU(NUM_FU),
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req_we  (req_we),
    .req_addr(req_addr),
    .req_data(req_data),
    .grant   (grant),
    .fu_stall(fu_stall),
    .rf_we   (rf_we),
    .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
      $display("check %-14s observed %0h expected %0h ok", tag, obs, exp);
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fu(input int i, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    req_addr[i*ADDR_W +: ADDR_W] = a;
    req_data[i*DATA_W +: DATA_W] = d;
  endtask

  initial begin
    logic [3:0] exp_g;
    n_total  = 0;
    n_pass   = 0;
    rst      = 1'b1;
    req_we   = 4'b1111;
    req_addr = '0;
    req_data = '0;
    for (int i = 0; i < NUM_FU; i++) set_fu(i, ADDR_W'(i + 1), DATA_W'(i + 1));

    // 1. Reset holds grant/stall low regardless of requests.
    #2;
    chk("rst_grant", 64'(grant), 64'h0);
    chk("rst_stall", 64'(fu_stall), 64'h0);
    chk("rst_rf_we", 64'(rf_we), 64'h0);
    chk("rst_busy",  64'(busy), 64'h0);
    tick();
    rst = 1'b0;
    #1;
    chk("post_rst_grant", 64'(grant), 64'h1);
    chk("post_rst_stall", 64'(fu_stall), 64'hE);
    req_we = 4'b0000;
    tick();
    chk("idle_rf_we", 64'(rf_we), 64'h0);
    chk("idle_busy",  64'(busy), 64'h0);

    // 2. Single request from FU2.
    set_fu(2, 5'd7, 64'hDEAD);
    req_we = 4'b0100;
    #1;
    chk("single_grant", 64'(grant), 64'h4);
    chk("single_stall", 64'(fu_stall), 64'h0);
    tick();
    chk("single_rf_we",  64'(rf_we), 64'h1);
    chk("single_waddr",  64'(rf_waddr), 64'h7);
    chk("single_wdata",  64'(rf_wdata), 64'hDEAD);
    chk("single_busy",   64'(busy), 64'h1);
    req_we = 4'b0000;
    tick();
    chk("drop_rf_we", 64'(rf_we), 64'h0);
    chk("hold_waddr", 64'(rf_waddr), 64'h7);
    chk("hold_wdata", 64'(rf_wdata), 64'hDEAD);

    // 3. All four request continuously from a fresh pointer.
    rst = 1'b1;
    #1;
    rst = 1'b0;
    for (int i = 0; i < NUM_FU; i++) set_fu(i, ADDR_W'(i + 10), DATA_W'(i + 100));
    req_we = 4'b1111;
    #1;
    for (int k = 0; k < 5; k++) begin
`ifdef REGWRITE_ARB_FIXED_PRIO_EN
      exp_g = 4'b0001;
`else
      exp_g = 4'b0001 << (k % 4);
`endif
      chk($sformatf("rr_grant%0d", k), 64'(grant), 64'(exp_g));
      chk($sformatf("rr_stall%0d", k), 64'(fu_stall), 64'(4'b1111 & ~exp_g));
      tick();
      chk($sformatf("rr_rf_we%0d", k), 64'(rf_we), 64'h1);
`ifdef REGWRITE_ARB_FIXED_PRIO_EN
      chk($sformatf("rr_waddr%0d", k), 64'(rf_waddr), 64'd10);
`else
      chk($sformatf("rr_waddr%0d", k), 64'(rf_waddr), 64'(10 + (k % 4)));
`endif
    end
    req_we = 4'b0000;
    tick();

    // 4. Same-address collision: FU1 and FU3 both write r5.
    rst = 1'b1;
    #1;
    rst = 1'b0;
    set_fu(1, 5'd5, 64'd1);
    set_fu(3, 5'd5, 64'd3);
    req_we = 4'b1010;
    #1;
    chk("col_grant1", 64'(grant), 64'h2);
    chk("col_stall1", 64'(fu_stall), 64'h8);
    tick();
    req_we = 4'b1000;
    #1;
    chk("col_w1_addr", 64'(rf_waddr), 64'd5);
    chk("col_w1_data", 64'(rf_wdata), 64'd1);
    chk("col_grant2",  64'(grant), 64'h8);
    chk("col_stall2",  64'(fu_stall), 64'h0);
    tick();
    req_we = 4'b0000;
    chk("col_w2_we",   64'(rf_we), 64'h1);
    chk("col_w2_addr", 64'(rf_waddr), 64'd5);
    chk("col_w2_data", 64'(rf_wdata), 64'd3);
    tick();
    chk("col_end_we",  64'(rf_we), 64'h0);

    // 5. Reset asserted while a write sits in the rf_* registers.
    set_fu(2, 5'd9, 64'h55);
    req_we = 4'b0100;
    #1;
    chk("mid_grant", 64'(grant), 64'h4);
    tick();
    chk("mid_rf_we_set", 64'(rf_we), 64'h1);
    rst = 1'b1;
    #1;
    chk("mid_rf_we_clr", 64'(rf_we), 64'h0);
    chk("mid_waddr_clr", 64'(rf_waddr), 64'h0);
    chk("mid_wdata_clr", 64'(rf_wdata), 64'h0);
    chk("mid_grant_rst", 64'(grant), 64'h0);
    chk("mid_stall_rst", 64'(fu_stall), 64'h0);
    tick();
    chk("mid_rf_we_hold", 64'(rf_we), 64'h0);
    chk("mid_busy",       64'(busy), 64'h0);
    req_we = 4'b0000;
    rst = 1'b0;
    tick();

    // 6. FU1 and FU3 held for three cycles.
    req_we = 4'b1010;
    #1;
    for (int k = 0; k < 3; k++) begin
`ifdef REGWRITE_ARB_FIXED_PRIO_EN
      exp_g = 4'b0010;
`else
      exp_g = (k == 1) ? 4'b1000 : 4'b0010;
`endif
      chk($sformatf("hold_grant%0d", k), 64'(grant), 64'(exp_g));
      tick();
    end
    req_we = 4'b0000;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #50000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
